multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Multi-cycle MIPS control unit: a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back, driving the datapath one stage per clock. It replaces the single-cycle opcode decoder in the processor core. It adds a memory wait handshake, an illegal-opcode trap, an optional jump path and a parametrised ALUOp width. It sits between the instruction register's opcode field and the multi-cycle datapath.

## Interface
- OPCODE_W, 6, opcode field width
- ALUOP_W, 3, ALUOp width (min 3)
- ENABLE_JUMP, 1, 1 = J decoded; 0 = J treated as illegal
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  OPCODE_W  instruction opcode, valid from DECODE onward
- MemReady  in  1  memory access completes this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  out  1 each  PC/memory/IR controls
- MemToReg, RegisterWrite, RegDst, ALUSrcA  out  1 each  register-file/ALU controls
- ALUSrcB  out  2  ALU B mux: 00 reg, 01 const 4, 10 sign-ext imm, 11 shifted imm
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target
- ALUOp  out  ALUOP_W  000 add, 001 sub, 010 R-type funct
- IllegalOp  out  1  one-cycle pulse on undefined opcode
- State  out  4  current state, debug

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP.
- Any output not listed for a state is 0.
- IDLE: all outputs 0; transitions to FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
  - IRWrite and PCWrite are 1 only when MemReady=1. This is the only Mealy gating.
  - Holds while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcB=11, ALUOp=000 (branch target precompute).
  - Next state by opcode: LW/SW→MEMADR, R→EXEC, ADDI→ADDIEX, BEQ→BRANCH.
  - J→JUMP if ENABLE_JUMP, else TRAP. Anything else→TRAP.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next state MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady, then MEMWB.
- MEMWB: RegisterWrite=1, MemToReg=1, RegDst=0. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until MemReady, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next state ALUWB.
- ALUWB: RegisterWrite=1, RegDst=1, MemToReg=0. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next state ADDIWB.
- ADDIWB: RegisterWrite=1, RegDst=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- TRAP: IllegalOp=1, no writes. Next state FETCH; the PC has already advanced by 4.
- ALUOp codes are zero-extended to ALUOP_W.

## Timing
- Reset: state=IDLE immediately (asynchronous), all outputs 0, State=0. First FETCH is the clock edge after rst_n rises.
- Cycles per instruction with MemReady held 1:
  - R 4, LW 5, SW 4, ADDI 4, BEQ 3, J 3, illegal 3.
- Each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds one cycle. Outputs stay constant during the stall.
- IRWrite/PCWrite each pulse exactly once per fetch.
- Opcode is sampled only in DECODE and MEMADR; changes elsewhere are ignored.
- rst_n asserted mid-instruction: aborts at once to IDLE, outputs 0. No partial write completes after assertion.
- MemWrite/RegisterWrite never assert in the same cycle.

## Structure
- Package mcu_pkg holds:
  - opcode localparams
  - state enum with 4-bit encoding, IDLE=0
  - ALUOp codes
  - ALUSrcB/PCSource encodings
- One sub-module, mcu_output_decode: combinational state→control-word map with MemReady gating.
- The top module holds the state register and next-state logic.

## Test plan
- Reset then R-type with MemReady=1 → states FETCH, DECODE, EXEC, ALUWB; RegisterWrite=1 and RegDst=1 only in cycle 4; ALUOp=010 in EXEC.
- LW with MemReady low for 2 cycles in MEMRD → 7 cycles total; MemRead held 3 cycles in MEMRD; MemToReg=1 in MEMWB.
- Fetch stall of 3 cycles → IRWrite and PCWrite each high exactly one cycle.
- BEQ → PCWriteCond=1, ALUOp=001, PCSource=01 in cycle 3. J with ENABLE_JUMP=0 → IllegalOp pulse, back to FETCH.
- Opcode 111111 → TRAP for one cycle, IllegalOp=1, no write strobes.
- rst_n low during MEMWR → all outputs 0 within the same cycle, IDLE, then FETCH after release.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// opcodes, FSM states, ALU/mux select codes and the control word.
package mcu_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mcu_output_decode.sv
// Moore state -> control word map; only the fetch
// IR/PC strobes look at MemReady.
module mcu_output_decode
  import mcu_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_IDLE: ;
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SHIMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_TRAP: ctrl.illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: state register and
// next-state logic, outputs from mcu_output_decode.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned ALUOP_W     = 3,
  parameter bit          ENABLE_JUMP = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemToReg,
  output logic                RegisterWrite,
  output logic                RegDst,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSource,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                IllegalOp,
  output logic [3:0]          State
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  logic op_r, op_lw, op_sw, op_beq, op_addi, op_j;

  assign op_r    = (Opcode == OPCODE_W'(OP_R));
  assign op_lw   = (Opcode == OPCODE_W'(OP_LW));
  assign op_sw   = (Opcode == OPCODE_W'(OP_SW));
  assign op_beq  = (Opcode == OPCODE_W'(OP_BEQ));
  assign op_addi = (Opcode == OPCODE_W'(OP_ADDI));
  assign op_j    = (Opcode == OPCODE_W'(OP_J));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          op_lw, op_sw:        state_d = S_MEMADR;
          op_r:                state_d = S_EXEC;
          op_addi:             state_d = S_ADDIEX;
          op_beq:              state_d = S_BRANCH;
          op_j && ENABLE_JUMP: state_d = S_JUMP;
          default:             state_d = S_TRAP;
        endcase
      end
      // a non-store here falls back to the harmless read path
      S_MEMADR: state_d = op_sw ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB,
      S_BRANCH, S_JUMP, S_TRAP:
                state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  mcu_output_decode u_dec (
    .state     (state_q),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );

  assign PCWrite       = ctrl.pc_write;
  assign PCWriteCond   = ctrl.pc_write_cond;
  assign IorD          = ctrl.iord;
  assign MemRead       = ctrl.mem_read;
  assign MemWrite      = ctrl.mem_write;
  assign IRWrite       = ctrl.ir_write;
  assign MemToReg      = ctrl.mem_to_reg;
  assign RegisterWrite = ctrl.reg_write;
  assign RegDst        = ctrl.reg_dst;
  assign ALUSrcA       = ctrl.alu_src_a;
  assign ALUSrcB       = ctrl.alu_src_b;
  assign PCSource      = ctrl.pc_source;
  assign ALUOp         = ALUOP_W'(ctrl.alu_op);
  assign IllegalOp     = ctrl.illegal_op;
  assign State         = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction cycle plans
// built from the instruction rules, random opcodes and stalls.
module tb_multicycle_control_unit;
  import mcu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic       MemReady = 1'b1;

  logic       pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a;
  logic       m2r_a, rw_a, rdst_a, asa_a, ill_a;
  logic [1:0] asb_a, pcs_a;
  logic [2:0] aop_a;
  logic [3:0] st_a;
  logic       pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b;
  logic       m2r_b, rw_b, rdst_b, asa_b, ill_b;
  logic [1:0] asb_b, pcs_b;
  logic [2:0] aop_b;
  logic [3:0] st_b;

  multicycle_control_unit #(.ENABLE_JUMP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .IorD(iord_a),
    .MemRead(mrd_a), .MemWrite(mwr_a), .IRWrite(irw_a),
    .MemToReg(m2r_a), .RegisterWrite(rw_a), .RegDst(rdst_a),
    .ALUSrcA(asa_a), .ALUSrcB(asb_a), .PCSource(pcs_a),
    .ALUOp(aop_a), .IllegalOp(ill_a), .State(st_a)
  );

  multicycle_control_unit #(.ENABLE_JUMP(1'b0)) dut_nj (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .IorD(iord_b),
    .MemRead(mrd_b), .MemWrite(mwr_b), .IRWrite(irw_b),
    .MemToReg(m2r_b), .RegisterWrite(rw_b), .RegDst(rdst_b),
    .ALUSrcA(asa_b), .ALUSrcB(asb_b), .PCSource(pcs_b),
    .ALUOp(aop_b), .IllegalOp(ill_b), .State(st_b)
  );

  always #5 clk = ~clk;

  logic [17:0] cw_a, cw_b;
  assign cw_a = {pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a,
                 rw_a, rdst_a, asa_a, asb_a, pcs_a, aop_a, ill_a};
  assign cw_b = {pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b,
                 rw_b, rdst_b, asa_b, asb_b, pcs_b, aop_b, ill_b};

  typedef struct {
    logic        mr;
    logic [5:0]  op;
    logic [3:0]  sa;
    logic [17:0] ca;
    logic [3:0]  sb;
    logic [17:0] cb;
  } step_t;

  step_t plan[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [17:0] cw(
    input bit pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, asa,
    input logic [1:0] asb, pcs, input logic [2:0] aop, input bit ill);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, asa,
            asb, pcs, aop, ill};
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic mr, input logic [5:0] op,
                      input state_t sa, input logic [17:0] ca,
                      input state_t sb, input logic [17:0] cb);
    step_t e;
    e.mr = mr; e.op = op;
    e.sa = sa; e.ca = ca;
    e.sb = sb; e.cb = cb;
    plan.push_back(e);
  endtask

  task automatic push1(input logic mr, input logic [5:0] op,
                       input state_t s, input logic [17:0] c);
    push(mr, op, s, c, s, c);
  endtask

  // One instruction: fs fetch stalls, ms memory stalls.
  task automatic instr(input logic [5:0] op, input int fs, input int ms);
    logic [17:0] fc;
    fc = cw(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 3'b000, 0);
    for (int i = 0; i < fs; i++) push1(1'b0, rop(), S_FETCH, fc);
    push1(1'b1, rop(), S_FETCH,
          cw(1,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 3'b000, 0));
    push1(rbit(), op, S_DECODE,
          cw(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b000, 0));
    if (op == OP_LW || op == OP_SW) begin
      push1(rbit(), op, S_MEMADR,
            cw(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b000, 0));
      if (op == OP_LW) begin
        for (int i = 0; i <= ms; i++)
          push1(i == ms, rop(), S_MEMRD,
                cw(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0));
        push1(rbit(), rop(), S_MEMWB,
              cw(0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b000, 0));
      end else begin
        for (int i = 0; i <= ms; i++)
          push1(i == ms, rop(), S_MEMWR,
                cw(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0));
      end
    end else if (op == OP_R) begin
      push1(rbit(), rop(), S_EXEC,
            cw(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b010, 0));
      push1(rbit(), rop(), S_ALUWB,
            cw(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'b000, 0));
    end else if (op == OP_ADDI) begin
      push1(rbit(), rop(), S_ADDIEX,
            cw(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b000, 0));
      push1(rbit(), rop(), S_ADDIWB,
            cw(0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 3'b000, 0));
    end else if (op == OP_BEQ) begin
      push1(rbit(), rop(), S_BRANCH,
            cw(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b001, 0));
    end else if (op == OP_J) begin
      push(rbit(), rop(),
           S_JUMP, cw(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 0),
           S_TRAP, cw(0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 1));
    end else begin
      push1(rbit(), rop(), S_TRAP,
            cw(0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 1));
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_plan();
    step_t e;
    while (plan.size() > 0) begin
      e = plan.pop_front();
      @(posedge clk);
      #1;
      MemReady = e.mr;
      Opcode   = e.op;
      @(negedge clk);
      chk("state_j", 32'(st_a), 32'(e.sa));
      chk("ctrl_j", 32'(cw_a), 32'(e.ca));
      chk("state_nj", 32'(st_b), 32'(e.sb));
      chk("ctrl_nj", 32'(cw_b), 32'(e.cb));
      chk("wr_excl", 32'(mwr_a & rw_a), 32'd0);
    end
  endtask

  logic [5:0] ops [6];
  logic [5:0] op;

  initial begin
    ops[0] = OP_R;   ops[1] = OP_LW;   ops[2] = OP_SW;
    ops[3] = OP_BEQ; ops[4] = OP_ADDI; ops[5] = OP_J;

    repeat (2) @(negedge clk);
    chk("rst_state", 32'(st_a), 32'd0);
    chk("rst_ctrl", 32'(cw_a), 32'd0);
    chk("rst_state_nj", 32'(st_b), 32'd0);
    chk("rst_ctrl_nj", 32'(cw_b), 32'd0);
    rst_n = 1'b1;

    instr(OP_R, 0, 0);
    instr(OP_LW, 0, 2);
    instr(OP_ADDI, 3, 0);
    instr(OP_BEQ, 0, 0);
    instr(OP_J, 0, 0);
    instr(6'b111111, 0, 0);
    instr(OP_SW, 1, 1);
    run_plan();

    repeat (40) begin
      int k;
      k = $urandom_range(0, 6);
      if (k < 6) op = ops[k];
      else begin
        op = rop();
        if (op == OP_R || op == OP_LW || op == OP_SW ||
            op == OP_BEQ || op == OP_ADDI || op == OP_J)
          op = 6'b111111;
      end
      instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_plan();

    // reset in the middle of a stalled store
    instr(OP_SW, 0, 3);
    repeat (3) void'(plan.pop_back());
    run_plan();
    @(posedge clk);
    #1;
    MemReady = 1'b0;
    #1;
    chk("memwr_held", 32'(mwr_a), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_state", 32'(st_a), 32'd0);
    chk("abort_ctrl", 32'(cw_a), 32'd0);
    chk("abort_ctrl_nj", 32'(cw_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    instr(OP_R, 0, 0);
    run_plan();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
